// File: rtl/lsu_ctrl_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// funct3 encodings, byte-mask shapes and the funct3-to-access-size decode.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BMASK_B = 4'b0001;
  localparam logic [3:0] BMASK_H = 4'b0011;
  localparam logic [3:0] BMASK_W = 4'b1111;

  // Reserved funct3 codes fall through to a full-word access.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = SZ_B;
      F3_H, F3_HU: f3_size = SZ_H;
      default:     f3_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_align.sv
// Byte-lane steering: store mask/data placement, alignment check, load extract/extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; stateless, follows its inputs.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  req_f3,
  input  logic [1:0]  req_off,
  input  logic [31:0] st_data,
  output logic [3:0]  bmask,
  output logic [31:0] wdata,
  output logic        misalign,
  input  logic [2:0]  rsp_f3,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  lsu_size_e  req_sz;
  lsu_size_e  rsp_sz;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        sext;

  always_comb begin
    req_sz   = f3_size(req_f3);
    bmask    = BMASK_W;
    wdata    = '0;
    misalign = 1'b0;
    case (req_sz)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = req_off[0];
      default: misalign = |req_off;
    endcase
    // Halfword placement uses only off[1], so an odd halfword lands on its containing half.
    if (is_store) begin
      case (req_sz)
        SZ_B: begin
          bmask = BMASK_B << req_off;
          wdata = {24'b0, st_data[7:0]} << {req_off, 3'b000};
        end
        SZ_H: begin
          bmask = BMASK_H << {req_off[1], 1'b0};
          wdata = {16'b0, st_data[15:0]} << {req_off[1], 4'b0000};
        end
        default: begin
          bmask = BMASK_W;
          wdata = st_data;
        end
      endcase
    end
  end

  always_comb begin
    rsp_sz  = f3_size(rsp_f3);
    ld_byte = rdata[{rsp_off, 3'b000} +: 8];
    ld_half = rdata[{rsp_off[1], 4'b0000} +: 16];
    sext    = ~rsp_f3[2];
    case (rsp_sz)
      SZ_B:    ld_data = {{24{sext & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{sext & ld_half[15]}}, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// LSU initiator to data memory (optional trap on misaligned access: LSU_MISALIGN_TRAP_EN).
// Latency: READY tied high gives 2 stall cycles, o_done in cycle 3; each READY wait adds one.
// Backpressure: request held stable with o_VALID until i_READY; core stalled throughout.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int STORE_PRIO = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ld_en,
  input  logic              i_st_en,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_st_data,
  output logic [31:0]       o_ld_data,
  output logic              o_stall,
  output logic              o_done,
  output logic              o_misalign,
  output logic [ADDR_W-1:0] o_ADDR,
  output logic [31:0]       o_WDATA,
  output logic [3:0]        o_BMASK,
  output logic              o_WREN,
  output logic              o_VALID,
  input  logic              i_READY,
  input  logic [31:0]       i_RDATA
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        bmask_q;
  logic [31:0]       wdata_q;
  logic [31:0]       ld_data_q;
  logic              wren_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;

  logic              req;
  logic              is_store;
  logic              trap;
  logic              load_fields;
  logic              capture;
  logic              trap_take;
  logic [3:0]        align_bm;
  logic [31:0]       align_wd;
  logic [31:0]       align_ld;
  logic              align_mis;
  logic              unused_ok;

  assign req      = i_ld_en | i_st_en;
  assign is_store = i_st_en & ((STORE_PRIO != 0) | ~i_ld_en);

  lsu_align u_align (
    .is_store (is_store),
    .req_f3   (i_funct3),
    .req_off  (i_addr[1:0]),
    .st_data  (i_st_data),
    .bmask    (align_bm),
    .wdata    (align_wd),
    .misalign (align_mis),
    .rsp_f3   (f3_q),
    .rsp_off  (off_q),
    .rdata    (i_RDATA),
    .ld_data  (align_ld)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  assign trap       = align_mis;
  assign o_misalign = mis_q;
  assign unused_ok  = ^i_addr[31:ADDR_W];

  // High only in the RESP cycle that follows a trapped request.
  always_ff @(posedge i_clk) begin
    if (i_rst) mis_q <= 1'b0;
    else       mis_q <= trap_take;
  end
`else
  assign trap       = 1'b0;
  assign o_misalign = 1'b0;
  assign unused_ok  = ^{i_addr[31:ADDR_W], align_mis};
`endif

  always_comb begin
    state_d     = state_q;
    o_stall     = 1'b0;
    o_VALID     = 1'b0;
    o_done      = 1'b0;
    load_fields = 1'b0;
    capture     = 1'b0;
    trap_take   = 1'b0;
    if (!i_rst) begin
      case (state_q)
        IDLE: begin
          o_stall = req;
          if (req) begin
            load_fields = ~trap;
            trap_take   = trap;
            state_d     = trap ? RESP : REQ;
          end
        end
        REQ: begin
          o_VALID = 1'b1;
          o_stall = 1'b1;
          if (i_READY) begin
            capture = 1'b1;
            state_d = RESP;
          end
        end
        // Core still presents the finished instruction here, so inputs are ignored.
        RESP: begin
          o_done  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      bmask_q   <= '0;
      wdata_q   <= '0;
      wren_q    <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      ld_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_fields) begin
        addr_q  <= {i_addr[ADDR_W-1:2], 2'b00};
        bmask_q <= align_bm;
        wdata_q <= align_wd;
        wren_q  <= is_store;
        f3_q    <= i_funct3;
        off_q   <= i_addr[1:0];
      end
      if (capture)        ld_data_q <= align_ld;
      else if (trap_take) ld_data_q <= '0;
    end
  end

  assign o_ADDR    = addr_q;
  assign o_BMASK   = bmask_q;
  assign o_WDATA   = wdata_q;
  assign o_WREN    = wren_q;
  assign o_ld_data = ld_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table of single accesses plus wait-state, misalignment and reset sequences.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  localparam int ADDR_W = 18;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_ld_en, i_st_en;
  logic [2:0]        i_funct3;
  logic [31:0]       i_addr, i_st_data, i_RDATA;
  logic              i_READY;
  logic [31:0]       o_ld_data, o_WDATA;
  logic              o_stall, o_done, o_misalign, o_WREN, o_VALID;
  logic [ADDR_W-1:0] o_ADDR;
  logic [3:0]        o_BMASK;

  always #5 i_clk = ~i_clk;

  lsu_ctrl #(.ADDR_W(ADDR_W), .STORE_PRIO(1)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ld_en    (i_ld_en),
    .i_st_en    (i_st_en),
    .i_funct3   (i_funct3),
    .i_addr     (i_addr),
    .i_st_data  (i_st_data),
    .o_ld_data  (o_ld_data),
    .o_stall    (o_stall),
    .o_done     (o_done),
    .o_misalign (o_misalign),
    .o_ADDR     (o_ADDR),
    .o_WDATA    (o_WDATA),
    .o_BMASK    (o_BMASK),
    .o_WREN     (o_WREN),
    .o_VALID    (o_VALID),
    .i_READY    (i_READY),
    .i_RDATA    (i_RDATA)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rd;
    logic [31:0] e_addr;
    logic [3:0]  e_bm;
    logic [31:0] e_data;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  int          r_stall, r_done_cyc, r_vcnt;
  logic        r_stable, r_valid_at_done, r_mis, r_wren;
  logic [31:0] r_addr, r_wd, r_ld;
  logic [3:0]  r_bm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rd, input int lat);
    @(posedge i_clk); #1;
    i_ld_en = ld; i_st_en = st; i_funct3 = f3; i_addr = addr;
    i_st_data = sd; i_RDATA = rd; i_READY = 1'b0;
    r_stall = 0; r_done_cyc = -1; r_vcnt = 0; r_stable = 1'b1;
    r_valid_at_done = 1'b1; r_mis = 1'b0; r_ld = 'x;
    r_addr = 'x; r_wd = 'x; r_bm = 'x; r_wren = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(negedge i_clk);
      if (o_stall) r_stall++;
      if (o_VALID) begin
        if (r_vcnt == 0) begin
          r_addr = 32'(o_ADDR); r_wd = o_WDATA; r_bm = o_BMASK; r_wren = o_WREN;
        end else if ({32'(o_ADDR), o_WDATA, o_BMASK, o_WREN} !== {r_addr, r_wd, r_bm, r_wren}) begin
          r_stable = 1'b0;
        end
        r_vcnt++;
      end
      if (o_done) begin
        r_done_cyc = c; r_valid_at_done = o_VALID; r_mis = o_misalign; r_ld = o_ld_data;
        break;
      end
      i_READY = o_VALID && (r_vcnt > lat);
    end
    i_ld_en = 1'b0; i_st_en = 1'b0; i_READY = 1'b0;
    chk("done_within_budget", 32'(r_done_cyc > 0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[15];
    vecs[0]  = '{1'b0, 1'b1, F3_W,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0,          32'h100,   4'hF, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 1'b1, F3_B,  32'h0000_0103, 32'h0000_00AB, 32'h0,          32'h100,   4'h8, 32'hAB00_0000};
    vecs[2]  = '{1'b0, 1'b1, F3_H,  32'h0000_0206, 32'h1234_ABCD, 32'h0,          32'h204,   4'hC, 32'hABCD_0000};
    vecs[3]  = '{1'b0, 1'b1, F3_B,  32'h0000_0001, 32'h0000_0055, 32'h0,          32'h000,   4'h2, 32'h0000_5500};
    vecs[4]  = '{1'b0, 1'b1, F3_H,  32'h0000_0000, 32'hFFFF_5678, 32'h0,          32'h000,   4'h3, 32'h0000_5678};
    vecs[5]  = '{1'b1, 1'b0, F3_B,  32'h0000_0102, 32'h0,          32'h80FF_1234, 32'h100,   4'hF, 32'hFFFF_FFFF};
    vecs[6]  = '{1'b1, 1'b0, F3_BU, 32'h0000_0102, 32'h0,          32'h80FF_1234, 32'h100,   4'hF, 32'h0000_00FF};
    vecs[7]  = '{1'b1, 1'b0, F3_H,  32'h0000_0102, 32'h0,          32'h80FF_1234, 32'h100,   4'hF, 32'hFFFF_80FF};
    vecs[8]  = '{1'b1, 1'b0, F3_HU, 32'h0000_0102, 32'h0,          32'h80FF_1234, 32'h100,   4'hF, 32'h0000_80FF};
    vecs[9]  = '{1'b1, 1'b0, F3_W,  32'hABCF_FFFC, 32'h0,          32'h1234_5678, 32'h3FFFC, 4'hF, 32'h1234_5678};
    vecs[10] = '{1'b1, 1'b0, F3_B,  32'h0000_0101, 32'h0,          32'h0000_7F00, 32'h100,   4'hF, 32'h0000_007F};
    vecs[11] = '{1'b1, 1'b1, F3_W,  32'h0000_0010, 32'hCAFE_F00D, 32'h0,          32'h010,   4'hF, 32'hCAFE_F00D};
    vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h0000_0008, 32'h0,         32'h89AB_CDEF, 32'h008,   4'hF, 32'h89AB_CDEF};
    vecs[13] = '{1'b1, 1'b0, F3_HU, 32'h0000_0200, 32'h0,          32'h1111_8001, 32'h200,   4'hF, 32'h0000_8001};
    vecs[14] = '{1'b1, 1'b0, F3_H,  32'h0000_0202, 32'h0,          32'h7FFF_0000, 32'h200,   4'hF, 32'h0000_7FFF};

    i_rst = 1'b1; i_ld_en = 1'b0; i_st_en = 1'b0; i_funct3 = '0; i_addr = '0;
    i_st_data = '0; i_RDATA = '0; i_READY = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_ctrl", {27'b0, o_VALID, o_WREN, o_stall, o_done, o_misalign}, 32'h0);
    chk("rst_addr_bmask", {10'b0, o_BMASK, o_ADDR}, 32'h0);
    chk("rst_wdata", o_WDATA, 32'h0);
    chk("rst_ld_data", o_ld_data, 32'h0);
    i_rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      access(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].sd, vecs[i].rd, 0);
      chk($sformatf("v%0d_addr", i), r_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_bmask", i), 32'(r_bm), 32'(vecs[i].e_bm));
      chk($sformatf("v%0d_wren", i), 32'(r_wren), 32'(vecs[i].st));
      if (vecs[i].st) chk($sformatf("v%0d_wdata", i), r_wd, vecs[i].e_data);
      else            chk($sformatf("v%0d_ld_data", i), r_ld, vecs[i].e_data);
      chk($sformatf("v%0d_stall_cycles", i), 32'(r_stall), 32'd2);
      chk($sformatf("v%0d_done_cycle", i), 32'(r_done_cyc), 32'd3);
      chk($sformatf("v%0d_valid_at_done", i), 32'(r_valid_at_done), 32'd0);
      chk($sformatf("v%0d_misalign", i), 32'(r_mis), 32'd0);
    end

    // Memory holds off READY for three VALID cycles.
    access(1'b0, 1'b1, F3_H, 32'h0000_0012, 32'h0000_BEEF, 32'h0, 3);
    chk("wait_addr", r_addr, 32'h10);
    chk("wait_bmask", 32'(r_bm), 32'hC);
    chk("wait_wdata", r_wd, 32'hBEEF_0000);
    chk("wait_stable", 32'(r_stable), 32'd1);
    chk("wait_valid_cycles", 32'(r_vcnt), 32'd4);
    chk("wait_stall_cycles", 32'(r_stall), 32'd5);
    chk("wait_done_cycle", 32'(r_done_cyc), 32'd6);
    chk("wait_valid_at_done", 32'(r_valid_at_done), 32'd0);

    access(1'b1, 1'b0, F3_W, 32'h0000_0101, 32'h0, 32'h1122_3344, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_flag", 32'(r_mis), 32'd1);
    chk("mis_no_valid", 32'(r_vcnt), 32'd0);
    chk("mis_done_cycle", 32'(r_done_cyc), 32'd2);
    chk("mis_ld_data", r_ld, 32'h0);
`else
    chk("mis_flag", 32'(r_mis), 32'd0);
    chk("mis_addr", r_addr, 32'h100);
    chk("mis_done_cycle", 32'(r_done_cyc), 32'd3);
    chk("mis_ld_data", r_ld, 32'h1122_3344);
`endif

    // Reset while a request is outstanding.
    @(posedge i_clk); #1;
    i_ld_en = 1'b1; i_funct3 = F3_W; i_addr = 32'h40; i_READY = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rstreq_valid_before", 32'(o_VALID), 32'd1);
    i_rst = 1'b1; i_ld_en = 1'b0;
    @(negedge i_clk);
    chk("rstreq_valid_after", 32'(o_VALID), 32'd0);
    chk("rstreq_stall_after", 32'(o_stall), 32'd0);
    chk("rstreq_addr_after", 32'(o_ADDR), 32'h0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rstreq_idle_valid", 32'(o_VALID), 32'd0);
    chk("rstreq_idle_done", 32'(o_done), 32'd0);
    access(1'b1, 1'b0, F3_W, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 0);
    chk("rstreq_fresh_addr", r_addr, 32'h44);
    chk("rstreq_fresh_ld", r_ld, 32'h0BAD_F00D);
    chk("rstreq_fresh_done", 32'(r_done_cyc), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Initiator side of the LSU↔data memory valid/ready interface. Takes one load/store request per instruction from the core datapath and registers a word-aligned request (address, byte mask, lane-shifted write data). It drives the VALID/READY handshake, stalls the core until the memory acknowledges, and returns sign- or zero-extended load data. Sits between the core execute stage and the data memory block.

Parameters:
ADDR_W, 18, memory-side byte address width; o_ADDR width.
STORE_PRIO, 1, if 1 a store wins when i_ld_en and i_st_en are both high; if 0 a load wins.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_ld_en  in  1  load request from core, level, held until o_stall falls
i_st_en  in  1  store request from core, level, held until o_stall falls
i_funct3  in  3  RV32I funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010
i_addr  in  32  byte address; only [ADDR_W-1:0] used
i_st_data  in  32  store data, right-justified
o_ld_data  out  32  extended load result, valid while o_done=1
o_stall  out  1  freeze core
o_done  out  1  one-cycle pulse: access complete
o_misalign  out  1  misalignment pulse (optional feature only)
o_ADDR  out  ADDR_W  word-aligned address {i_addr[ADDR_W-1:2],2'b00}
o_WDATA  out  32  lane-shifted store data
o_BMASK  out  4  byte enables
o_WREN  out  1  1 write, 0 read
o_VALID  out  1  request valid
i_READY  in  1  memory acknowledge
i_RDATA  in  32  read word, valid when i_READY=1

Behaviour:
- Reset: state IDLE. All outputs 0: o_VALID, o_WREN, o_BMASK, o_WDATA, o_ADDR, o_ld_data, o_stall, o_done, o_misalign. Reset during REQ drops o_VALID at that edge; the in-flight access is abandoned.
- FSM IDLE→REQ→RESP→IDLE.
- IDLE: o_stall = i_ld_en|i_st_en (combinational). On request, register o_ADDR, o_BMASK, o_WDATA, o_WREN and byte offset/funct3, then go to REQ.
- REQ: o_VALID=1, o_stall=1. All request fields stay stable until i_READY=1. On i_READY: register the extracted load data into o_ld_data, then go to RESP.
- RESP: o_VALID=0, o_stall=0, o_done=1, then IDLE. Request inputs are ignored in RESP because they still belong to the completed instruction. o_VALID is therefore low for at least one cycle between accesses, which the memory's new-request edge detection requires.
- Latency with i_READY tied high: 2 stall cycles, o_done in the 3rd cycle. An extra READY delay of N cycles adds N stall cycles.
- Mask/data (a=i_addr[1:0]):
  - SB: BMASK=0001<<a, WDATA=st_data[7:0]<<8a.
  - SH: BMASK=0011<<{a[1],0}, WDATA=st_data[15:0]<<16a[1].
  - SW: BMASK=1111.
  - Loads: BMASK=1111, WREN=0.
- Load extract: LB/LBU take byte a; LH/LHU take half a[1]; LB/LH sign-extend, LBU/LHU zero-extend.
- Unknown funct3: treated as the W variant.
- Misalignment without the feature: LH/SH with a[0]=1 use a[1]; LW/SW ignore a.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: LH/LHU/SH with a[0]=1, or LW/SW with a≠0, issues no request (o_VALID stays 0). IDLE goes directly to RESP with o_misalign=1 and o_done=1; o_ld_data=0.
- Undefined: o_misalign is tied 0; alignment handled as in Behaviour.

Decomposition:
- singlecycle_pkg additions:
  - lsu_state_e {IDLE,REQ,RESP}
  - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU
  - BMASK_B/H/W constants
- Sub-module lsu_align (combinational): produces mask, shifted write data, and load extract/extend. lsu_ctrl keeps the FSM and registers.

Test Plan:
- SW 0xDEADBEEF @0x100, READY=1 → BMASK=1111, WDATA=0xDEADBEEF, ADDR=0x100, WREN=1, o_stall 2 cycles, o_done cycle 3.
- SB 0x000000AB @0x103 → BMASK=1000, WDATA=0xAB000000, ADDR=0x100.
- RDATA=0x80FF1234 @0x102: LB→0xFFFFFFFF, LBU→0x000000FF, LH→0xFFFF80FF, LHU→0x000080FF.
- READY held low 3 cycles after VALID → VALID/ADDR/WDATA/BMASK stable throughout, o_stall 5 cycles, VALID low in the cycle after READY.
- LW @0x101 → with macro: o_misalign=1, no VALID, o_done next cycle; without macro: ADDR=0x100, normal read.
- i_rst asserted in REQ → next cycle o_VALID=0, o_stall=0, state IDLE; a fresh load completes normally.
